// File: rtl/vga_timing_ctrl.sv
// VGA raster timing generator: pixel-tick divider, h/v counters, registered valid/hsync/vsync.
// Latency: valid/hsync/vsync match h_cnt/v_cnt in the same cycle (one pixel tick later with VGA_OUT_PIPE_EN).
// Backpressure: none; enable is a level request, and a frame in flight always completes before stopping.
//
// Ports: clk, rst_n (async active-low), enable (run request) ->
//        pix_en, h_cnt[9:0], v_cnt[9:0], valid, hsync, vsync (active-low), frame_start, running.
// Optional macro VGA_OUT_PIPE_EN: valid/hsync/vsync are delayed by one pixel tick
// to line up with a registered pixel generator. h_cnt/v_cnt are unaffected.
module vga_timing_ctrl #(
    parameter int CLK_DIV  = 4,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    output logic       pix_en,
    output logic [9:0] h_cnt,
    output logic [9:0] v_cnt,
    output logic       valid,
    output logic       hsync,
    output logic       vsync,
    output logic       frame_start,
    output logic       running
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = $clog2(CLK_DIV);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0] H_SYNC_S = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] H_SYNC_E = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] V_SYNC_S = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] V_SYNC_E = 10'(V_ACTIVE + V_FP + V_SYNC);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [DIV_W-1:0] div_cnt, div_nxt;
    logic [9:0]       h_nxt, v_nxt;
    logic             wrap;
    logic             valid_nxt, hsync_nxt, vsync_nxt, fs_nxt;
    logic             valid_r, hsync_r, vsync_r;

    assign running = (state != IDLE);
    assign pix_en  = running && (div_cnt == DIV_LAST);
    // Last tick of the last pixel of the frame: the next presented position is (0,0).
    assign wrap    = pix_en && (h_cnt == H_LAST) && (v_cnt == V_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (enable) state_nxt = RUN;
            // Dropping enable on the wrap tick itself means the frame is already done.
            RUN:     if (!enable) state_nxt = wrap ? IDLE : DRAIN;
            DRAIN:   if (enable) state_nxt = RUN;
                     else if (wrap) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Next counter values; timing flags are derived from these so that the
    // registered flags line up with the registered counters.
    always_comb begin
        div_nxt = div_cnt;
        h_nxt   = h_cnt;
        v_nxt   = v_cnt;
        if (state_nxt == IDLE || state == IDLE) begin
            div_nxt = '0;
            h_nxt   = '0;
            v_nxt   = '0;
        end else if (pix_en) begin
            div_nxt = '0;
            if (h_cnt == H_LAST) begin
                h_nxt = '0;
                v_nxt = (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
            end else begin
                h_nxt = h_cnt + 10'd1;
            end
        end else begin
            div_nxt = div_cnt + 1'b1;
        end
    end

    always_comb begin
        valid_nxt = 1'b0;
        hsync_nxt = 1'b1;
        vsync_nxt = 1'b1;
        fs_nxt    = wrap && (state_nxt == RUN);
        if (state_nxt != IDLE) begin
            valid_nxt = (h_nxt < H_ACT) && (v_nxt < V_ACT);
            hsync_nxt = !((h_nxt >= H_SYNC_S) && (h_nxt < H_SYNC_E));
            vsync_nxt = !((v_nxt >= V_SYNC_S) && (v_nxt < V_SYNC_E));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt     <= '0;
            h_cnt       <= '0;
            v_cnt       <= '0;
            valid_r     <= 1'b0;
            hsync_r     <= 1'b1;
            vsync_r     <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            div_cnt     <= div_nxt;
            h_cnt       <= h_nxt;
            v_cnt       <= v_nxt;
            valid_r     <= valid_nxt;
            hsync_r     <= hsync_nxt;
            vsync_r     <= vsync_nxt;
            frame_start <= fs_nxt;
        end
    end

`ifdef VGA_OUT_PIPE_EN
    logic valid_d, hsync_d, vsync_d;

    // Each pixel tick captures the flags of the pixel just finished.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_d <= 1'b0;
            hsync_d <= 1'b1;
            vsync_d <= 1'b1;
        end else if (state_nxt == IDLE) begin
            valid_d <= 1'b0;
            hsync_d <= 1'b1;
            vsync_d <= 1'b1;
        end else if (pix_en) begin
            valid_d <= valid_r;
            hsync_d <= hsync_r;
            vsync_d <= vsync_r;
        end
    end

    assign valid = valid_d;
    assign hsync = hsync_d;
    assign vsync = vsync_d;
`else
    assign valid = valid_r;
    assign hsync = hsync_r;
    assign vsync = vsync_r;
`endif

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Bench for vga_timing_ctrl using a reduced raster (30x17 pixels, 4 clks/pixel).
// Expected outputs come from a position formula: pixel index = clocks since RUN entry / CLK_DIV.
// Expectations are queued when a cycle's inputs are driven and compared after the clock edge.
module tb_vga_timing_ctrl;

    localparam int D   = 4;
    localparam int HA  = 16, HFP = 4, HS = 6, HBP = 4;
    localparam int VA  = 10, VFP = 2, VS = 2, VBP = 3;
    localparam int HT  = HA + HFP + HS + HBP;
    localparam int VT  = VA + VFP + VS + VBP;
    localparam int FRAME = HT * VT;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       enable = 1'b0;
    logic       pix_en, valid, hsync, vsync, frame_start, running;
    logic [9:0] h_cnt, v_cnt;

    vga_timing_ctrl #(
        .CLK_DIV(D), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .pix_en(pix_en),
        .h_cnt(h_cnt), .v_cnt(v_cnt), .valid(valid), .hsync(hsync),
        .vsync(vsync), .frame_start(frame_start), .running(running)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       pe;
        logic [9:0] h;
        logic [9:0] v;
        logic       vl;
        logic       hs;
        logic       vs;
        logic       fs;
        logic       rn;
    } exp_t;

    exp_t q[$];
    int   n_chk = 0;
    int   n_err = 0;

    // Model state: mode 0=idle 1=run 2=drain, k = clocks since RUN entry.
    int   mode = 0;
    int   k = 0;
    logic fs_m = 1'b0;
    logic dvl = 1'b0, dhs = 1'b1, dvs = 1'b1;
    int   cyc = 0;
    int   last_fs = -1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic int hpos(int m, int kk);
        return (m == 0) ? 0 : (kk / D) % HT;
    endfunction

    function automatic int vpos(int m, int kk);
        return (m == 0) ? 0 : ((kk / D) / HT) % VT;
    endfunction

    function automatic logic f_valid(int h, int v);
        return (h < HA) && (v < VA);
    endfunction

    function automatic logic f_hs(int h);
        return !((h >= HA + HFP) && (h < HA + HFP + HS));
    endfunction

    function automatic logic f_vs(int v);
        return !((v >= VA + VFP) && (v < VA + VFP + VS));
    endfunction

    function automatic exp_t model_out();
        exp_t e;
        int   h, v;
        h    = hpos(mode, k);
        v    = vpos(mode, k);
        e.h  = 10'(h);
        e.v  = 10'(v);
        e.pe = (mode != 0) && (k % D == D - 1);
        e.rn = (mode != 0);
        e.fs = fs_m;
        e.vl = (mode != 0) ? f_valid(h, v) : 1'b0;
        e.hs = (mode != 0) ? f_hs(h) : 1'b1;
        e.vs = (mode != 0) ? f_vs(v) : 1'b1;
`ifdef VGA_OUT_PIPE_EN
        e.vl = dvl;
        e.hs = dhs;
        e.vs = dvs;
`endif
        return e;
    endfunction

    task automatic model_reset();
        mode = 0;
        k    = 0;
        fs_m = 1'b0;
        dvl  = 1'b0;
        dhs  = 1'b1;
        dvs  = 1'b1;
    endtask

    task automatic step(input logic en, input logic rst);
        exp_t e, got;
        int   h0, v0;
        logic pe, wrap;
        @(negedge clk);
        enable = en;
        rst_n  = rst;
        h0   = hpos(mode, k);
        v0   = vpos(mode, k);
        pe   = (mode != 0) && (k % D == D - 1);
        wrap = pe && ((k / D) % FRAME == FRAME - 1);
        if (!rst) begin
            model_reset();
        end else if (mode == 0) begin
            fs_m = 1'b0;
            if (en) begin
                mode = 1;
                k    = 0;
            end
        end else begin
            if (pe) begin
                dvl = f_valid(h0, v0);
                dhs = f_hs(h0);
                dvs = f_vs(v0);
            end
            if (wrap && !en) begin
                model_reset();
            end else begin
                mode = en ? 1 : 2;
                k    = k + 1;
                fs_m = wrap;
            end
        end
        if (mode == 0) begin
            dvl = 1'b0;
            dhs = 1'b1;
            dvs = 1'b1;
        end
        q.push_back(model_out());
        @(posedge clk);
        #1;
        cyc++;
        got.pe = pix_en; got.h = h_cnt; got.v = v_cnt; got.vl = valid;
        got.hs = hsync; got.vs = vsync; got.fs = frame_start; got.rn = running;
        e = q.pop_front();
        check("pix_en", 32'(got.pe), 32'(e.pe));
        check("h_cnt", 32'(got.h), 32'(e.h));
        check("v_cnt", 32'(got.v), 32'(e.v));
        check("valid", 32'(got.vl), 32'(e.vl));
        check("hsync", 32'(got.hs), 32'(e.hs));
        check("vsync", 32'(got.vs), 32'(e.vs));
        check("frame_start", 32'(got.fs), 32'(e.fs));
        check("running", 32'(got.rn), 32'(e.rn));
        if (mode == 0) begin
            last_fs = -1;
        end else if (frame_start === 1'b1) begin
            if (last_fs >= 0) check("frame_gap", 32'(cyc - last_fs), 32'(FRAME * D));
            last_fs = cyc;
        end
    endtask

    task automatic check_idle_now(input string tag);
        check({tag, "_pix_en"}, 32'(pix_en), 32'd0);
        check({tag, "_h"}, 32'(h_cnt), 32'd0);
        check({tag, "_v"}, 32'(v_cnt), 32'd0);
        check({tag, "_valid"}, 32'(valid), 32'd0);
        check({tag, "_hsync"}, 32'(hsync), 32'd1);
        check({tag, "_vsync"}, 32'(vsync), 32'd1);
        check({tag, "_fs"}, 32'(frame_start), 32'd0);
        check({tag, "_running"}, 32'(running), 32'd0);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #1 check_idle_now("por");
        // Reset held with enable high: stays idle.
        repeat (3) step(1'b1, 1'b0);
        // Reset released, enable low: stays idle.
        repeat (3) step(1'b0, 1'b1);
        // Two full frames plus change: wraps, syncs, frame_start spacing.
        for (int i = 0; i < 2 * FRAME * D + 100; i++) step(1'b1, 1'b1);
        // Drop enable mid-frame at line 5; frame must drain to idle.
        for (int i = 0; i < FRAME * D && vpos(mode, k) != 5; i++) step(1'b1, 1'b1);
        for (int i = 0; i < FRAME * D + 10 && mode != 0; i++) step(1'b0, 1'b1);
        check("drained_to_idle", 32'(mode == 0), 32'd1);
        repeat (10) step(1'b0, 1'b1);
        // Restart, then toggle enable inside DRAIN and let it drain again.
        for (int i = 0; i < FRAME * D && vpos(mode, k) != 3; i++) step(1'b1, 1'b1);
        repeat (50) step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        repeat (50) step(1'b0, 1'b1);
        for (int i = 0; i < FRAME * D + 10 && mode != 0; i++) step(1'b0, 1'b1);
        // Run to (12,7), then assert reset between clock edges.
        for (int i = 0; i < 2 * FRAME * D && !(hpos(mode, k) == 12 && vpos(mode, k) == 7); i++)
            step(1'b1, 1'b1);
        check("reached_12_7", 32'(hpos(mode, k) == 12 && vpos(mode, k) == 7), 32'd1);
        #2 rst_n = 1'b0;
        #1 check_idle_now("mid_rst");
        model_reset();
        step(1'b1, 1'b0);
        // Re-enable: first tick four clocks after entering RUN.
        repeat (60) step(1'b1, 1'b1);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/vga_timing_ctrl.md
VGA_TIMING_CTRL -- requirements
Module: vga_timing_ctrl

Interface
REQ-001 Parameter CLK_DIV, default 4: system clocks per pixel (100 MHz -> 25 MHz pixel rate); legal range 2..16.
REQ-002 Parameters H_ACTIVE/H_FP/H_SYNC/H_BP, defaults 640/16/96/48: horizontal timing in pixels (H_TOTAL = 800).
REQ-003 Parameters V_ACTIVE/V_FP/V_SYNC/V_BP, defaults 480/10/2/33: vertical timing in lines (V_TOTAL = 525).
REQ-004 One clock; reset is asynchronous and active-low.
REQ-005 clk  input  1  system clock; all state changes on its rising edge.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 enable  input  1  request to run the raster; level-sensitive.
REQ-008 pix_en  output  1  one-clk pixel tick; counters advance only on it.
REQ-009 h_cnt  output  10  horizontal pixel position, 0..H_TOTAL-1.
REQ-010 v_cnt  output  10  vertical line position, 0..V_TOTAL-1.
REQ-011 valid  output  1  high when h_cnt < H_ACTIVE and v_cnt < V_ACTIVE.
REQ-012 hsync  output  1  active-low horizontal sync.
REQ-013 vsync  output  1  active-low vertical sync.
REQ-014 frame_start  output  1  one-clk pulse when the raster wraps to (0,0).
REQ-015 running  output  1  high in states RUN and DRAIN.

Function
REQ-016 FSM states IDLE, RUN, DRAIN; IDLE->RUN when enable=1; RUN->DRAIN when enable=0; DRAIN->RUN when enable=1; DRAIN->IDLE on the frame wrap.
REQ-017 In IDLE: divider, h_cnt, v_cnt held at 0; pix_en=0; valid=0; hsync=vsync=1; frame_start=0.
REQ-018 Divider counts 0..CLK_DIV-1 in RUN/DRAIN; pix_en=1 in the cycle the divider equals CLK_DIV-1.
REQ-019 On pix_en: h_cnt increments; at H_TOTAL-1 wraps to 0 and v_cnt increments; v_cnt at V_TOTAL-1 wraps to 0.
REQ-020 First pixel tick after IDLE->RUN occurs CLK_DIV clks after entering RUN; (0,0) is presented for exactly CLK_DIV clks.
REQ-021 hsync=0 iff H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC (656..751 default).
REQ-022 vsync=0 iff V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC (490..491 default).
REQ-023 valid, hsync, vsync are registered and always consistent with the h_cnt/v_cnt values presented in the same cycle.
REQ-024 frame_start asserts in the clk where h_cnt=0,v_cnt=0 is first presented after a wrap; not on IDLE->RUN start.
REQ-025 enable dropping mid-frame: raster completes the frame (DRAIN); IDLE entered on the wrap clk, no frame_start pulse.
REQ-026 enable toggling low-high within DRAIN: no raster disturbance; counters continue uninterrupted.
REQ-027 Counter arithmetic unsigned 10-bit; values never exceed TOTAL-1.

Reset
REQ-028 rst_n=0 forces IDLE and REQ-017 output values immediately, regardless of clk, including mid-frame.
REQ-029 After rst_n release, block remains IDLE until enable is sampled high.

Configuration
REQ-030 Macro VGA_OUT_PIPE_EN defined: valid, hsync, vsync delayed by exactly one pixel tick (registered on pix_en) to align with a registered pixel generator; h_cnt/v_cnt unchanged; delayed copies reset to 0/1/1 and forced to 0/1/1 in IDLE.
REQ-031 Macro VGA_OUT_PIPE_EN undefined: REQ-023 alignment applies; no extra stage.

Verification
REQ-032 Reset, enable=1 held -> pix_en every 4th clk; h_cnt reaches 799 then 0; v_cnt increments 0->1 on that wrap.
REQ-033 Full frame -> hsync low exactly 96 pixels per line (h 656..751); vsync low exactly 2 lines (v 490..491); 800x525 ticks between frame_start pulses.
REQ-034 Check valid at (639,0)=1, (640,0)=0, (0,479)=1, (0,480)=0.
REQ-035 Drop enable at v_cnt=100 -> running stays 1 until (799,524) completes, then IDLE with counters 0, hsync=vsync=1, no frame_start.
REQ-036 Assert rst_n=0 between clk edges at (300,200) -> outputs go to REQ-017 values immediately; re-enable -> first tick 4 clks later.
REQ-037 With VGA_OUT_PIPE_EN -> hsync falls when h_cnt=657, valid falls when h_cnt=641.
